// File: rtl/processinho_sequencer.sv
// Operator-entry sequencer for the processinho datapath: walks regA/regB/opcode entry,
// waits for the ULA result and converts it to packed BCD with a serial shift-add-3 engine.
module processinho_sequencer #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned RES_W   = 8,
  parameter int unsigned ULA_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_enter,
  input  logic              btn_clear,
  input  logic [DATA_W-1:0] switches,
  input  logic [RES_W-1:0]  ula_result,
  output logic [DATA_W-1:0] operando,
  output logic              setRegA,
  output logic              setRegB,
  output logic [OP_W-1:0]   ula_operation,
  output logic              latch_ula,
  output logic [11:0]       bcd,
  output logic              bcd_valid,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam int unsigned BCD_W  = 12;
  localparam int unsigned DIGITS = BCD_W / 4;
  localparam int unsigned CNT_W  = $clog2(ULA_LAT + 1);
  localparam int unsigned ITER_W = $clog2(RES_W + 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_CONV = 3'd4,
    S_SHOW = 3'd5
  } state_t;

  state_t              state;
  logic                enter_q;
  logic                enter_ev;
  logic [CNT_W-1:0]    cnt;
  logic [ITER_W-1:0]   iter;
  logic [RES_W-1:0]    shreg;
  logic [BCD_W-1:0]    bcd_work;
  logic [BCD_W-1:0]    bcd_adj_c;
  logic [BCD_W+RES_W-1:0] shift_c;

  // Rising edge of the enter button; enter_q is preset on reset so a held button is ignored.
  assign enter_ev  = btn_enter & ~enter_q;
  assign state_dbg = state;

  // One double-dabble step: correct digits >= 5, then shift the result bit in.
  always_comb begin
    bcd_adj_c = bcd_work;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_work[4*d +: 4] >= 4'd5) begin
        bcd_adj_c[4*d +: 4] = bcd_work[4*d +: 4] + 4'd3;
      end
    end
    shift_c = {bcd_adj_c, shreg} << 1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_A;
      enter_q       <= 1'b1;
      operando      <= '0;
      ula_operation <= '0;
      bcd           <= '0;
      setRegA       <= 1'b0;
      setRegB       <= 1'b0;
      latch_ula     <= 1'b0;
      bcd_valid     <= 1'b0;
      busy          <= 1'b0;
      cnt           <= '0;
      iter          <= '0;
      shreg         <= '0;
      bcd_work      <= '0;
    end else begin
      enter_q   <= btn_enter;
      setRegA   <= 1'b0;
      setRegB   <= 1'b0;
      latch_ula <= 1'b0;

      if (btn_clear) begin
        // Abort: operand and opcode registers keep their last values.
        state     <= S_A;
        bcd       <= '0;
        bcd_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_A: begin
            if (enter_ev) begin
              operando <= switches;
              setRegA  <= 1'b1;
              state    <= S_B;
            end
          end
          S_B: begin
            if (enter_ev) begin
              operando <= switches;
              setRegB  <= 1'b1;
              state    <= S_OP;
            end
          end
          S_OP: begin
            if (enter_ev) begin
              ula_operation <= switches[OP_W-1:0];
              latch_ula     <= 1'b1;
              cnt           <= CNT_W'(ULA_LAT);
              busy          <= 1'b1;
              state         <= S_EXEC;
            end
          end
          S_EXEC: begin
            if (cnt == CNT_W'(1)) begin
              shreg    <= ula_result;
              bcd_work <= '0;
              iter     <= ITER_W'(RES_W);
              state    <= S_CONV;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_CONV: begin
            {bcd_work, shreg} <= shift_c;
            iter              <= iter - ITER_W'(1);
            if (iter == ITER_W'(1)) begin
              bcd       <= shift_c[RES_W +: BCD_W];
              bcd_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= S_SHOW;
            end
          end
          S_SHOW: begin
            if (enter_ev) begin
              bcd_valid <= 1'b0;
              state     <= S_A;
            end
          end
          default: begin
            state     <= S_A;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_processinho_sequencer.sv
// Scoreboard bench for processinho_sequencer: stimulus pushes expected strobe/BCD events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_processinho_sequencer;

  localparam int K_A   = 0;
  localparam int K_B   = 1;
  localparam int K_OP  = 2;
  localparam int K_BCD = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        btn_enter = 1'b0;
  logic        btn_clear = 1'b0;
  logic [3:0]  switches = 4'd0;
  logic [7:0]  ula_result = 8'd0;
  logic [3:0]  operando;
  logic        setRegA;
  logic        setRegB;
  logic [3:0]  ula_operation;
  logic        latch_ula;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [2:0]  state_dbg;

  typedef struct {
    int kind;
    int val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  logic bv_prev = 1'b0;

  processinho_sequencer dut (
    .clock(clock), .reset(reset), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .switches(switches), .ula_result(ula_result), .operando(operando),
    .setRegA(setRegA), .setRegB(setRegB), .ula_operation(ula_operation),
    .latch_ula(latch_ula), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic chk_ev(input int kind, input int val);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event kind=%0d got=%0h want=none", kind, val);
    end else begin
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_value", val, e.val);
    end
  endtask

  // Monitor: every strobe and each rising bcd_valid consumes one expected event.
  always @(negedge clock) begin
    if (reset) begin
      if (setRegA)              chk_ev(K_A, int'(operando));
      if (setRegB)              chk_ev(K_B, int'(operando));
      if (latch_ula)            chk_ev(K_OP, int'(ula_operation));
      if (bcd_valid && !bv_prev) chk_ev(K_BCD, int'(bcd));
    end
    bv_prev = bcd_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] sw);
    switches  = sw;
    btn_enter = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    tick(1);
  endtask

  task automatic full_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                         input logic [7:0] res, input int want_bcd);
    int n;
    push(K_A, int'(a));
    press(a);
    check("state_after_a", int'(state_dbg), 1);
    push(K_B, int'(b));
    press(b);
    check("state_after_b", int'(state_dbg), 2);
    ula_result = res;
    push(K_OP, int'(op));
    push(K_BCD, want_bcd);
    switches  = op;
    btn_enter = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    n = 1;
    check("latch_at_t1", int'(latch_ula), 1);
    check("busy_exec", int'(busy), 1);
    check("state_exec", int'(state_dbg), 3);
    while (!bcd_valid && n < 40) begin
      tick(1);
      n++;
    end
    check("bcd_latency", n, 10);
    check("busy_show", int'(busy), 0);
    check("state_show", int'(state_dbg), 5);
    press(4'd0);
    check("state_return", int'(state_dbg), 0);
    check("valid_dropped", int'(bcd_valid), 0);
    check("bcd_held", int'(bcd), want_bcd);
  endtask

  initial begin
    // Power-up reset
    tick(3);
    check("rst_state", int'(state_dbg), 0);
    check("rst_operando", int'(operando), 0);
    check("rst_ula_op", int'(ula_operation), 0);
    check("rst_bcd", int'(bcd), 0);
    check("rst_strobes", int'({setRegA, setRegB, latch_ula}), 0);
    check("rst_valid_busy", int'({bcd_valid, busy}), 0);
    reset = 1'b1;
    tick(1);

    // Basic sequence and conversion boundaries
    full_op(4'd7, 4'd5, 4'd0, 8'd12,  12'h012);
    full_op(4'd1, 4'd2, 4'd3, 8'd255, 12'h255);
    full_op(4'd3, 4'd3, 4'd5, 8'd0,   12'h000);
    full_op(4'd9, 4'd4, 4'd10, 8'd100, 12'h100);

    // Held enter gives one setRegA only
    push(K_A, 6);
    switches  = 4'd6;
    btn_enter = 1'b1;
    tick(20);
    btn_enter = 1'b0;
    tick(1);
    check("held_state", int'(state_dbg), 1);

    // Enter pulses during EXEC/CONV are ignored
    push(K_B, 2);
    press(4'd2);
    ula_result = 8'd200;
    push(K_OP, 11);
    push(K_BCD, 12'h200);
    switches  = 4'd11;
    btn_enter = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    check("busy_state_t1", int'(state_dbg), 3);
    for (int k = 2; k <= 9; k++) begin
      btn_enter = (k % 2 == 0);
      tick(1);
      check("busy_state_conv", int'(state_dbg), 4);
    end
    btn_enter = 1'b0;
    tick(1);
    check("busy_state_show", int'(state_dbg), 5);
    check("busy_bcd", int'(bcd), 12'h200);
    press(4'd0);
    check("busy_return", int'(state_dbg), 0);

    // Clear in third CONV cycle
    push(K_A, 8);
    press(4'd8);
    push(K_B, 3);
    press(4'd3);
    ula_result = 8'd77;
    push(K_OP, 6);
    switches  = 4'd6;
    btn_enter = 1'b1;
    tick(1);
    btn_enter = 1'b0;
    tick(3);
    check("clr_in_conv", int'(state_dbg), 4);
    btn_clear = 1'b1;
    tick(1);
    btn_clear = 1'b0;
    check("clr_state", int'(state_dbg), 0);
    check("clr_bcd", int'(bcd), 0);
    check("clr_valid_busy", int'({bcd_valid, busy}), 0);
    check("clr_operando_hold", int'(operando), 3);
    check("clr_ula_op_hold", int'(ula_operation), 6);
    tick(12);
    check("clr_stays_idle", int'(state_dbg), 0);

    // Reset in S_B with enter held
    push(K_A, 4);
    press(4'd4);
    check("pre_rst_state", int'(state_dbg), 1);
    switches  = 4'd9;
    btn_enter = 1'b1;
    reset     = 1'b0;
    tick(1);
    check("mid_rst_state", int'(state_dbg), 0);
    check("mid_rst_operando", int'(operando), 0);
    check("mid_rst_ula_op", int'(ula_operation), 0);
    check("mid_rst_strobes", int'({setRegA, setRegB, latch_ula, bcd_valid, busy}), 0);
    reset = 1'b1;
    tick(5);
    check("held_after_rst", int'(state_dbg), 0);
    btn_enter = 1'b0;
    tick(1);

    full_op(4'd2, 4'd13, 4'd15, 8'd99, 12'h099);

    tick(3);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
